hdmi_pixel_line_buffer: RTL and testbench

//  Single-clock pixel FIFO between ddrPort1Controller read data and HDMI_Controller.

---
 rtl/hdmi_pixel_line_buffer.sv | 147 ++++++++++++++
 tb/tb_hdmi_pixel_line_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/hdmi_pixel_line_buffer.sv
// Pixel FIFO between the port-1 DDR read path and the HDMI controller.
// Watermark refill requests, end-of-line flush, sticky underflow/overflow flags.
module hdmi_pixel_line_buffer #(
  parameter int          DEPTH_LOG2    = 6,
  parameter int          BURST_LEN     = 32,
  parameter int          REFILL_THRESH = 32,
  parameter logic [23:0] BLANK_RGB     = 24'h0
) (
  input  logic                  clk,
  input  logic                  SYS_RESETn,
  input  logic [31:0]           wr_data,
  input  logic                  wr_valid,
  output logic                  refill_req,
  input  logic                  refill_ack,
  input  logic                  retrieve_data,
  input  logic                  end_line,
  output logic [23:0]           rgb_out,
  output logic                  rgb_valid,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underflow,
  output logic                  overflow,
  input  logic                  clear_errors
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] THRESH_L = LW'(REFILL_THRESH);
  localparam logic [LW-1:0] ROOM_L   = LW'(DEPTH - BURST_LEN);
  localparam logic [LW-1:0] LAST_L   = LW'(BURST_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]           level_q, level_d, cnt_q, cnt_d;
  logic [23:0]             rgb_out_q, rgb_out_d;
  logic                    rgb_valid_q, rgb_valid_d;
  logic                    underflow_q, underflow_d, overflow_q, overflow_d;
  logic                    full, empty, store_ok, wr_en, rd_en, last_word;
  logic [23:0]             mem_q [DEPTH];
  logic                    unused_hi;

  assign unused_hi = ^wr_data[31:24];

  always_comb begin
    full      = (level_q == DEPTH_L);
    empty     = (level_q == '0);
    // Words arriving while draining an abandoned burst are never stored.
    store_ok  = wr_valid && (state_q != S_DRAIN);
    wr_en     = store_ok && !full && !end_line;
    rd_en     = retrieve_data && !empty && !end_line;
    last_word = wr_valid && (cnt_q == LAST_L);

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    rgb_out_d   = rgb_out_q;
    rgb_valid_d = 1'b0;
    underflow_d = underflow_q && !clear_errors;
    overflow_d  = overflow_q && !clear_errors;

    if (end_line) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      wptr_d  = wptr_q + DEPTH_LOG2'(wr_en);
      rptr_d  = rptr_q + DEPTH_LOG2'(rd_en);
      level_d = level_q + LW'(wr_en) - LW'(rd_en);
      if (retrieve_data) begin
        if (rd_en) begin
          rgb_out_d   = mem_q[rptr_q];
          rgb_valid_d = 1'b1;
        end else begin
          rgb_out_d   = BLANK_RGB;
          underflow_d = 1'b1;
        end
      end
      if (store_ok && full) overflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (level_q < THRESH_L && level_q <= ROOM_L) state_d = S_REQ;
      end
      S_REQ: begin
        if (end_line) begin
          state_d = S_IDLE;
        end else if (refill_ack) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT, S_DRAIN: begin
        if (last_word) begin
          state_d = S_IDLE;
        end else begin
          if (wr_valid) cnt_d = cnt_q + 1'b1;
          // A flush mid-burst still has to swallow the rest of the burst.
          if (end_line) state_d = S_DRAIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge SYS_RESETn) begin
    if (!SYS_RESETn) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      cnt_q       <= '0;
      rgb_out_q   <= BLANK_RGB;
      rgb_valid_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      cnt_q       <= cnt_d;
      rgb_out_q   <= rgb_out_d;
      rgb_valid_q <= rgb_valid_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q] <= wr_data[23:0];
  end

  assign refill_req = (state_q == S_REQ);
  assign rgb_out    = rgb_out_q;
  assign rgb_valid  = rgb_valid_q;
  assign level      = level_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_hdmi_pixel_line_buffer.sv
// Scoreboard bench for hdmi_pixel_line_buffer: a queue-based pixel model predicts
// every popped pixel, the level and the sticky flags; a monitor checks pixel responses.
module tb_hdmi_pixel_line_buffer;
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        SYS_RESETn;
  logic [31:0] wr_data;
  logic        wr_valid, refill_req, refill_ack, retrieve_data, end_line;
  logic [23:0] rgb_out;
  logic        rgb_valid;
  logic [6:0]  level;
  logic        underflow, overflow, clear_errors;

  always #5 clk = ~clk;

  hdmi_pixel_line_buffer dut (
    .clk(clk), .SYS_RESETn(SYS_RESETn), .wr_data(wr_data), .wr_valid(wr_valid),
    .refill_req(refill_req), .refill_ack(refill_ack), .retrieve_data(retrieve_data),
    .end_line(end_line), .rgb_out(rgb_out), .rgb_valid(rgb_valid), .level(level),
    .underflow(underflow), .overflow(overflow), .clear_errors(clear_errors)
  );

  typedef struct {int cyc; bit vld; logic [23:0] rgb;} exp_t;
  exp_t        exp_q[$];
  logic [23:0] model_q[$];
  bit          m_unf, m_ovf, m_drain;
  int          checks = 0, failures = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare each predicted pixel response on the cycle it is due.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].cyc == cyc) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rgb_valid", {31'b0, rgb_valid}, {31'b0, e.vld});
        chk("rgb_out", {8'b0, rgb_out}, {8'b0, e.rgb});
      end else if (exp_q[0].cyc < cyc) begin
        void'(exp_q.pop_front());
        checks++;
        failures++;
        $display("FAIL missed_response actual=none expected=cycle %0d", cyc);
      end
    end
  end

  task automatic drive(input bit wv, input logic [31:0] wd, input bit pop,
                       input bit ack, input bit el, input bit clr);
    int n0;
    bit evu, evo;
    evu = 0;
    evo = 0;
    wr_valid = wv; wr_data = wd; retrieve_data = pop;
    refill_ack = ack; end_line = el; clear_errors = clr;
    n0 = model_q.size();
    if (el) begin
      model_q.delete();
    end else begin
      if (pop) begin
        if (n0 == 0) begin
          exp_q.push_back('{cyc + 1, 1'b0, 24'h0});
          evu = 1;
        end else begin
          exp_q.push_back('{cyc + 1, 1'b1, model_q.pop_front()});
        end
      end
      if (wv && !m_drain) begin
        if (n0 == DEPTH) evo = 1;
        else model_q.push_back(wd[23:0]);
      end
    end
    if (clr) begin m_unf = 0; m_ovf = 0; end
    if (evu) m_unf = 1;
    if (evo) m_ovf = 1;
    @(posedge clk); #1;
    wr_valid = 0; retrieve_data = 0; refill_ack = 0; end_line = 0; clear_errors = 0;
    chk("level", {25'b0, level}, model_q.size());
    chk("underflow", {31'b0, underflow}, {31'b0, m_unf});
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    SYS_RESETn = 0; wr_data = 0; wr_valid = 0; refill_ack = 0;
    retrieve_data = 0; end_line = 0; clear_errors = 0;
    m_unf = 0; m_ovf = 0; m_drain = 0;
    repeat (3) @(posedge clk);
    #1;
    // T1 reset
    chk("rst_level", {25'b0, level}, 0);
    chk("rst_refill_req", {31'b0, refill_req}, 0);
    chk("rst_rgb_out", {8'b0, rgb_out}, 0);
    chk("rst_rgb_valid", {31'b0, rgb_valid}, 0);
    chk("rst_flags", {30'b0, underflow, overflow}, 0);
    SYS_RESETn = 1;
    @(posedge clk); #1;
    chk("t1_refill_req", {31'b0, refill_req}, 1);

    // T2 fill one burst
    drive(0, 0, 0, 1, 0, 0);
    chk("t2_req_drop", {31'b0, refill_req}, 0);
    for (int i = 1; i <= 32; i++) drive(1, 32'hAA000000 + i, 0, 0, 0, 0);
    chk("t2_level", {25'b0, level}, 32);
    idle(3);
    chk("t2_no_req", {31'b0, refill_req}, 0);

    // T3 stream 33 pops
    for (int i = 0; i < 33; i++) drive(0, 0, 1, 0, 0, 0);
    chk("t3_underflow", {31'b0, underflow}, 1);
    drive(0, 0, 0, 0, 0, 1);
    chk("t3_clear", {31'b0, underflow}, 0);
    chk("t3_req", {31'b0, refill_req}, 1);

    // T4 watermark
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 32; i++) drive(1, $urandom, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(1, $urandom, 0, 0, 0, 0);
    chk("t4_level40", {25'b0, level}, 40);
    chk("t4_no_req", {31'b0, refill_req}, 0);
    for (int i = 0; i < 9; i++) drive(0, 0, 1, 0, 0, 0);
    chk("t4_level31", {25'b0, level}, 31);
    chk("t4_req_not_yet", {31'b0, refill_req}, 0);
    idle(1);
    chk("t4_req", {31'b0, refill_req}, 1);
    for (int i = 0; i < 5; i++) drive(1, $urandom, 1, 0, 0, 0);
    chk("t4_level_const", {25'b0, level}, 31);

    // T5 flush mid-burst
    drive(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, $urandom, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("t5_flush_level", {25'b0, level}, 0);
    m_drain = 1;
    for (int i = 0; i < 22; i++) begin
      drive(1, $urandom, 0, 0, 0, 0);
      chk("t5_drain_no_req", {31'b0, refill_req}, 0);
    end
    m_drain = 0;
    idle(1);
    chk("t5_req_again", {31'b0, refill_req}, 1);

    // T6 errors
    for (int i = 0; i < 65; i++) drive(1, $urandom, 0, 0, 0, 0);
    chk("t6_overflow", {31'b0, overflow}, 1);
    chk("t6_level", {25'b0, level}, 64);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 1);
    chk("t6_unf_set_wins", {31'b0, underflow}, 1);
    chk("t6_ovf_cleared", {31'b0, overflow}, 0);

    // Randomised traffic with no acknowledged burst
    for (int i = 0; i < 400; i++)
      drive($urandom_range(0, 1), $urandom, ($urandom_range(0, 99) < 45),
            0, 0, ($urandom_range(0, 15) == 0));
    idle(3);
    chk("rand_req_held", {31'b0, refill_req}, 1);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
